// File: rtl/block_section_ctrl.sv
// rtl/block_section_ctrl.sv - single-track block section controller with fail-safe FAULT latch
// Optional CODED_LAMP_EN: pulse-coded proceed lamp during GRANT instead of a steady lamp.
module block_section_ctrl #(
  parameter int CLEAR_CYC = 4,
  parameter int GRANT_TMO = 16,
  parameter int GUARD_CYC = 3,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_e,
  input  logic       req_w,
  input  logic       occupied,
  input  logic       track_fault,
  output logic       grant_e,
  output logic       grant_w,
  output logic       lamp_e,
  output logic       lamp_w,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR_CHK = 3'd1;
  localparam logic [2:0] S_GRANT     = 3'd2;
  localparam logic [2:0] S_OCCUPIED  = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(GRANT_TMO - 1);
  localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // side encoding: 0 = east, 1 = west
  logic [2:0]       state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             win_q, win_n;
  logic             last_q, last_n;
  logic             win_req;
  logic             lamp_on_n;

  assign win_req = win_q ? req_w : req_e;

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    win_n   = win_q;
    last_n  = last_q;
    if (track_fault) begin
      state_n = S_FAULT;
    end else begin
      case (state)
        S_IDLE: begin
          if (occupied) begin
            state_n = S_FAULT;
          end else if (req_e || req_w) begin
            state_n = S_CLEAR_CHK;
            cnt_n   = '0;
            if (req_e && !req_w)      win_n = 1'b0;
            else if (req_w && !req_e) win_n = 1'b1;
            else                      win_n = ~last_q;
          end
        end
        S_CLEAR_CHK: begin
          if (!win_req) begin
            state_n = S_RELEASE;
            cnt_n   = '0;
            last_n  = win_q;
          end else if (occupied) begin
            cnt_n = '0;
          end else if (cnt_q == CLR_LAST) begin
            state_n = S_GRANT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_ONE;
          end
        end
        S_GRANT: begin
          if (occupied) begin
            state_n = S_OCCUPIED;
          end else if (cnt_q == TMO_LAST) begin
            state_n = S_RELEASE;
            cnt_n   = '0;
            last_n  = win_q;
          end else begin
            cnt_n = cnt_q + CNT_ONE;
          end
        end
        S_OCCUPIED: begin
          if (!occupied) begin
            state_n = S_RELEASE;
            cnt_n   = '0;
            last_n  = win_q;
          end
        end
        S_RELEASE: begin
          // a train still on the track re-arms the full stop-hold period
          if (occupied) begin
            cnt_n = '0;
          end else if (cnt_q == GRD_LAST) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_ONE;
          end
        end
        S_FAULT: state_n = S_FAULT;
        default: state_n = S_FAULT;
      endcase
    end
  end

`ifdef CODED_LAMP_EN
  // lit on GRANT entry, then alternate so a stuck lamp never shows proceed
  assign lamp_on_n = (state_n == S_GRANT) && ((state != S_GRANT) || !(lamp_e || lamp_w));
`else
  assign lamp_on_n = (state_n == S_GRANT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      grant_e <= 1'b0;
      grant_w <= 1'b0;
      lamp_e  <= 1'b0;
      lamp_w  <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt_q   <= cnt_n;
      win_q   <= win_n;
      last_q  <= last_n;
      grant_e <= (state_n == S_GRANT) && !win_n;
      grant_w <= (state_n == S_GRANT) && win_n;
      lamp_e  <= lamp_on_n && !win_n;
      lamp_w  <= lamp_on_n && win_n;
      busy    <= (state_n != S_IDLE);
      fault   <= (state_n == S_FAULT);
    end
  end

endmodule
